// File: rtl/sram_word_ctrl.sv
`timescale 1ns/1ps
// sram_word_ctrl: serialises host word writes/reads into per-bit accesses on a 4x1 sram port.
// Optional WRITE_VERIFY_EN adds a read-back VERIFY pass after each write.
module sram_word_ctrl #(
   parameter int WORD_W = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [WORD_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [WORD_W-1:0] rd_data,
   output logic              busy,
   output logic              sram_DataIn,
   output logic              sram_RW,
   output logic [ADDR_W-1:0] sram_Address,
`ifdef WRITE_VERIFY_EN
   output logic              verify_done,
   output logic              verify_err,
`endif
   input  logic              sram_DataOut
);
   localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2;
`ifdef WRITE_VERIFY_EN
   localparam logic [1:0] VERIFY = 2'd3;
   logic err_acc, mism;
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORD_W - 1);
   logic [1:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [WORD_W-1:0] wd, sh, sh_nxt;
   logic              last;
   assign last         = cnt == LAST;
   assign cmd_ready    = state == IDLE;
   assign busy         = !cmd_ready;
   assign sram_RW      = state == WRITE;
   assign sram_Address = cmd_ready ? '0 : cnt;
   assign sram_DataIn  = sram_RW & wd[cnt];
`ifdef WRITE_VERIFY_EN
   assign mism = sram_DataOut != wd[cnt];
`endif
   always_comb begin
      sh_nxt      = sh;
      sh_nxt[cnt] = sram_DataOut;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         wd       <= '0;
         sh       <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
`ifdef WRITE_VERIFY_EN
         verify_done <= 1'b0;
         verify_err  <= 1'b0;
         err_acc     <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
`ifdef WRITE_VERIFY_EN
         verify_done <= 1'b0;
`endif
         if (cmd_ready) begin
            if (cmd_valid) begin
               state <= cmd_write ? WRITE : READ;
               wd    <= wr_data;
               cnt   <= '0;
               sh    <= '0;
`ifdef WRITE_VERIFY_EN
               if (cmd_write) begin
                  verify_err <= 1'b0;
                  err_acc    <= 1'b0;
               end
`endif
            end
         end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            sh  <= sh_nxt;
`ifdef WRITE_VERIFY_EN
            if (state == VERIFY) err_acc <= err_acc | mism;
`endif
            if (last) begin
`ifdef WRITE_VERIFY_EN
               state <= state == WRITE ? VERIFY : IDLE;
               if (state == VERIFY) begin
                  verify_done <= 1'b1;
                  verify_err  <= err_acc | mism;
               end
`else
               state <= IDLE;
`endif
               if (state == READ) begin
                  rd_data  <= sh_nxt;
                  rd_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sram_word_ctrl.sv
`timescale 1ns/1ps
// tb_sram_word_ctrl: directed bench with a behavioural 4x1 sram and a read-data scoreboard.
module tb_sram_word_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [3:0] wr_data = '0;
   logic       cmd_ready, rd_valid, busy, sram_DataIn, sram_RW, sram_DataOut;
   logic [3:0] rd_data;
   logic [1:0] sram_Address;
   logic [3:0] mem;
   logic       stuck2 = 1'b0;
`ifdef WRITE_VERIFY_EN
   logic       verify_done, verify_err;
`endif
   int checks = 0, errors = 0;
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   sram_word_ctrl #(.WORD_W(4), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .sram_DataIn(sram_DataIn), .sram_RW(sram_RW), .sram_Address(sram_Address),
`ifdef WRITE_VERIFY_EN
      .verify_done(verify_done), .verify_err(verify_err),
`endif
      .sram_DataOut(sram_DataOut));

   // sram shares rst; cell 2 can be forced to read 0 to model a stuck bit
   always_ff @(posedge clk)
      if (rst) mem <= '0;
      else if (sram_RW) mem[sram_Address] <= sram_DataIn;
   assign sram_DataOut = (stuck2 && sram_Address == 2'd2) ? 1'b0 : mem[sram_Address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, " ready"}, cmd_ready, 1);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " rw"}, sram_RW, 0);
      chk({tag, " addr"}, sram_Address, 0);
      chk({tag, " din"}, sram_DataIn, 0);
   endtask

   task automatic rd_pop(input string tag);
      chk({tag, " sb nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) chk({tag, " rd_data"}, rd_data, sb.pop_front());
   endtask

   task automatic issue(input logic w, input logic [3:0] d);
      cmd_valid = 1'b1; cmd_write = w; wr_data = d;
      if (!w) sb.push_back(4'bx);
      @(negedge clk);
   endtask

   // runs the access cycles after an accept and checks the completion cycle
   task automatic run(input logic w, input logic [3:0] d, input logic [3:0] alt, input logic verr, input logic [3:0] rexp);
      cmd_valid = 1'b0; wr_data = alt;
      if (!w) sb[sb.size()-1] = rexp;
      for (int i = 0; i < 4; i++) begin
         chk("acc rw", sram_RW, w);
         chk("acc addr", sram_Address, i);
         chk("acc din", sram_DataIn, w ? d[i] : 1'b0);
         chk("acc ready", cmd_ready, 0);
         chk("acc busy", busy, 1);
         chk("acc rd_valid", rd_valid, 0);
         @(negedge clk);
      end
`ifdef WRITE_VERIFY_EN
      if (w) for (int i = 0; i < 4; i++) begin
         chk("vfy rw", sram_RW, 0);
         chk("vfy addr", sram_Address, i);
         chk("vfy busy", busy, 1);
         chk("vfy done", verify_done, 0);
         @(negedge clk);
      end
      chk("done pulse", verify_done, w);
      if (w) chk("verify_err", verify_err, verr);
`endif
      idle_chk("end");
      chk("end rd_valid", rd_valid, !w);
      if (rd_valid) rd_pop("end");
   endtask

   initial begin
      logic [3:0] held;
      @(negedge clk); @(negedge clk);
      idle_chk("reset");
      chk("reset rd_valid", rd_valid, 0);
      chk("reset rd_data", rd_data, 0);
`ifdef WRITE_VERIFY_EN
      chk("reset vdone", verify_done, 0);
      chk("reset verr", verify_err, 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      issue(1, 4'b0101); run(1, 4'b0101, 4'b0101, 0, 0);
      issue(0, 0); run(0, 0, 0, 0, 4'b0101);
      held = rd_data;
      @(negedge clk);
      chk("hold rd_valid", rd_valid, 0);
      chk("hold rd_data", rd_data, held);
      // write held on cmd_valid through a read, accepted in the rd_valid cycle
      issue(0, 0);
      sb[sb.size()-1] = 4'b0101;
      cmd_valid = 1'b1; cmd_write = 1'b1; wr_data = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         chk("b2b ready", cmd_ready, 0);
         chk("b2b addr", sram_Address, i);
         @(negedge clk);
      end
      chk("b2b rd_valid", rd_valid, 1);
      chk("b2b ready", cmd_ready, 1);
      if (rd_valid) rd_pop("b2b");
      @(negedge clk);
      run(1, 4'b1111, 4'b1111, 0, 0);
      issue(0, 0); run(0, 0, 0, 0, 4'b1111);
      // reset during the second write cycle
      issue(1, 4'b1010);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst mid addr", sram_Address, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_chk("mid rst");
      chk("mid rst rd_valid", rd_valid, 0);
      issue(0, 0); run(0, 0, 0, 0, 4'b0000);
      issue(1, 4'b0011); run(1, 4'b0011, 4'b1100, 0, 0);
      issue(0, 0); run(0, 0, 0, 0, 4'b0011);
`ifdef WRITE_VERIFY_EN
      issue(1, 4'b1010); run(1, 4'b1010, 4'b1010, 0, 0);
      stuck2 = 1'b1;
      issue(1, 4'b1111); run(1, 4'b1111, 4'b1111, 1, 0);
      @(negedge clk);
      chk("verr held", verify_err, 1);
      issue(1, 4'b1010); run(1, 4'b1010, 4'b1010, 0, 0);
      stuck2 = 1'b0;
`endif
      chk("sb drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
